nand3_act_mon: RTL and testbench

NAND3_ACT_MON -- requirements
Module: nand3_act_mon

---
 rtl/nand3_act_mon.sv | 130 +++++++++++++
 tb/tb_nand3_act_mon.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nand3_act_mon.sv
`default_nettype none
// ============================================================================
// Module  : nand3_act_mon
// Brief   : Registered bitwise 3-input NAND lanes with a windowed, saturating
//           output-toggle activity counter.
// Revision: 1.0 - initial release
// ============================================================================
module nand3_act_mon #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 256
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [WIDTH-1:0] IN3,
    input  logic             EN,
    input  logic             START,
    output logic [WIDTH-1:0] QN,
    output logic [CNT_W-1:0] TOG_CNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             SAT
);

    localparam int TW    = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > TW) ? CNT_W : TW) + 1;
    localparam int WW    = $clog2(WINDOW + 1);

    localparam logic [SUM_W-1:0] C_CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [WW-1:0]    C_WIN_LAST = WW'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_clear;
    logic             w_count;

    logic [WIDTH-1:0] r_qn;
    logic [CNT_W-1:0] r_tog_cnt;
    logic             r_sat;
    logic [WW-1:0]    r_win;

    logic [WIDTH-1:0] w_qn_next;
    logic [TW-1:0]    w_tog;
    logic [SUM_W-1:0] w_sum;
    logic             w_ovf;

    function automatic logic [TW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [TW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + TW'(v[i]);
        end
        return acc;
    endfunction

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // START is only honoured outside MEASURE, so a window can never restart.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_state_nxt = ST_MEASURE;
                    w_clear     = 1'b1;
                end
            end
            ST_MEASURE: begin
                w_count = 1'b1;
                if (r_win == C_WIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_qn_next = ~(IN1 & IN2 & IN3);
    assign w_tog     = EN ? popcount(w_qn_next ^ r_qn) : '0;
    assign w_sum     = SUM_W'(r_tog_cnt) + SUM_W'(w_tog);
    assign w_ovf     = (w_sum > C_CNT_MAX);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_qn      <= '1;
            r_tog_cnt <= '0;
            r_sat     <= 1'b0;
            r_win     <= '0;
        end else begin
            if (EN) begin
                r_qn <= w_qn_next;
            end
            if (w_clear) begin
                r_tog_cnt <= '0;
                r_sat     <= 1'b0;
                r_win     <= '0;
            end else if (w_count) begin
                r_tog_cnt <= w_ovf ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
                r_sat     <= r_sat | w_ovf;
                r_win     <= r_win + WW'(1);
            end
        end
    end

    assign QN      = r_qn;
    assign TOG_CNT = r_tog_cnt;
    assign SAT     = r_sat;
    assign BUSY    = (r_state == ST_MEASURE);
    assign DONE    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nand3_act_mon.sv
`default_nettype none
// ============================================================================
// Module  : tb_nand3_act_mon
// Brief   : Directed self-checking bench for nand3_act_mon (CNT_W=4 and 16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_nand3_act_mon;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 4;

    logic             CLK = 1'b0;
    logic             RSTB = 1'b1;
    logic [WIDTH-1:0] IN1 = '0;
    logic [WIDTH-1:0] IN2 = '0;
    logic [WIDTH-1:0] IN3 = '0;
    logic             EN = 1'b0;
    logic             START = 1'b0;

    logic [WIDTH-1:0] QN4, QN16;
    logic [3:0]       TOG4;
    logic [15:0]      TOG16;
    logic             BUSY4, BUSY16, DONE4, DONE16, SAT4, SAT16;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    nand3_act_mon #(.WIDTH(WIDTH), .CNT_W(4), .WINDOW(WINDOW)) u_dut4 (
        .CLK(CLK), .RSTB(RSTB), .IN1(IN1), .IN2(IN2), .IN3(IN3),
        .EN(EN), .START(START), .QN(QN4), .TOG_CNT(TOG4),
        .BUSY(BUSY4), .DONE(DONE4), .SAT(SAT4)
    );

    nand3_act_mon #(.WIDTH(WIDTH), .CNT_W(16), .WINDOW(WINDOW)) u_dut16 (
        .CLK(CLK), .RSTB(RSTB), .IN1(IN1), .IN2(IN2), .IN3(IN3),
        .EN(EN), .START(START), .QN(QN16), .TOG_CNT(TOG16),
        .BUSY(BUSY16), .DONE(DONE16), .SAT(SAT16)
    );

    always #5 CLK = ~CLK;

    // Model: true (unclamped) toggle sum per window; counters show min(sum, max)
    // and SAT is simply "sum exceeded max", since the sum only grows.
    logic [WIDTH-1:0] m_qn   = '1;
    int               m_left = 0;
    bit               m_done = 1'b0;
    int               m_sum  = 0;

    always @(negedge RSTB) begin
        m_qn   = '1;
        m_left = 0;
        m_done = 1'b0;
        m_sum  = 0;
    end

    always @(posedge CLK) begin
        if (RSTB) begin
            logic [WIDTH-1:0] nq;
            int t;
            nq = EN ? ~(IN1 & IN2 & IN3) : m_qn;
            t  = $countones(nq ^ m_qn);
            if (m_left > 0) begin
                m_sum  = m_sum + t;
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end else if (START) begin
                m_sum  = 0;
                m_left = WINDOW;
                m_done = 1'b0;
            end
            m_qn = nq;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("qn4",   32'(QN4),    32'(m_qn));
            check("qn16",  32'(QN16),   32'(m_qn));
            check("busy",  32'(BUSY4),  32'(m_left > 0));
            check("done",  32'(DONE4),  32'(m_done));
            check("busy16",32'(BUSY16), 32'(m_left > 0));
            check("done16",32'(DONE16), 32'(m_done));
            check("tog4",  32'(TOG4),   32'((m_sum > 15) ? 15 : m_sum));
            check("sat4",  32'(SAT4),   32'(m_sum > 15));
            check("tog16", 32'(TOG16),  32'((m_sum > 65535) ? 65535 : m_sum));
            check("sat16", 32'(SAT16),  32'(m_sum > 65535));
        end
    end

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic en, input logic st);
        IN1 = a; IN2 = b; IN3 = c; EN = en; START = st;
        @(posedge CLK);
        #1;
    endtask

    task automatic stepv(input logic [3:0] v, input logic en, input logic st);
        step(v, v, v, en, st);
    endtask

    initial begin
        #1 RSTB = 1'b0;
        #12 RSTB = 1'b1;
        chk_en = 1'b1;
        check("rst_qn",   32'(QN4),   32'hF);
        check("rst_busy", 32'(BUSY4), 32'd0);
        check("rst_tog",  32'(TOG4),  32'd0);

        // Basic NAND capture and hold
        stepv(4'hF, 1'b1, 1'b0);  check("cap_f",  32'(QN4), 32'h0);
        stepv(4'h0, 1'b1, 1'b0);  check("cap_0",  32'(QN4), 32'hF);
        stepv(4'hF, 1'b0, 1'b0);  check("hold",   32'(QN4), 32'hF);

        // Full-toggle window: sum 16 clamps at 15 on the narrow counter
        stepv(4'h0, 1'b1, 1'b1);  check("st_busy", 32'(BUSY4), 32'd1);
        stepv(4'hF, 1'b1, 1'b0);
        stepv(4'h0, 1'b1, 1'b0);
        stepv(4'hF, 1'b1, 1'b0);  check("w_busy3", 32'(BUSY4), 32'd1);
        stepv(4'h0, 1'b1, 1'b0);
        check("w_done",  32'(DONE4), 32'd1);
        check("w_tog4",  32'(TOG4),  32'd15);
        check("w_sat4",  32'(SAT4),  32'd1);
        check("w_tog16", 32'(TOG16), 32'd16);
        check("w_sat16", 32'(SAT16), 32'd0);
        repeat (10) stepv(4'h0, 1'b0, 1'b0);
        check("hold_tog16", 32'(TOG16), 32'd16);
        check("hold_done",  32'(DONE16), 32'd1);

        // Restart from DONE; START mid-window ignored
        stepv(4'h0, 1'b1, 1'b1);
        check("rs_tog", 32'(TOG4), 32'd0);
        check("rs_busy", 32'(BUSY4), 32'd1);
        check("rs_sat", 32'(SAT4), 32'd0);
        stepv(4'hF, 1'b1, 1'b0);
        stepv(4'h0, 1'b1, 1'b1);
        stepv(4'hF, 1'b1, 1'b0);  check("ign_busy", 32'(BUSY4), 32'd1);
        stepv(4'h0, 1'b1, 1'b0);
        check("ign_done", 32'(DONE4), 32'd1);
        check("ign_tog16", 32'(TOG16), 32'd16);

        // Partial toggles: F->E (1), E->C (1), C->F (2), hold (0) = 4
        stepv(4'h0, 1'b1, 1'b1);
        step(4'h1, 4'hF, 4'hF, 1'b1, 1'b0);
        step(4'hF, 4'hF, 4'h3, 1'b1, 1'b0);
        stepv(4'h0, 1'b1, 1'b0);
        stepv(4'hF, 1'b0, 1'b0);
        check("part_tog4", 32'(TOG4), 32'd4);
        check("part_sat4", 32'(SAT4), 32'd0);
        check("part_done", 32'(DONE4), 32'd1);

        // Asynchronous reset mid-window
        stepv(4'h0, 1'b1, 1'b1);
        stepv(4'hF, 1'b1, 1'b0);
        check("pre_qn", 32'(QN4), 32'h0);
        #3 RSTB = 1'b0;
        #1;
        check("ar_qn",   32'(QN4),   32'hF);
        check("ar_tog",  32'(TOG4),  32'd0);
        check("ar_busy", 32'(BUSY4), 32'd0);
        check("ar_done", 32'(DONE4), 32'd0);
        check("ar_sat",  32'(SAT4),  32'd0);
        #2 RSTB = 1'b1;
        stepv(4'h0, 1'b1, 1'b0);
        check("ar_idle", 32'(BUSY4), 32'd0);

        // EN low for a whole window
        stepv(4'h0, 1'b1, 1'b1);
        stepv(4'hF, 1'b0, 1'b0);
        stepv(4'h0, 1'b0, 1'b0);
        stepv(4'hF, 1'b0, 1'b0);
        stepv(4'h5, 1'b0, 1'b0);
        check("en0_done", 32'(DONE4), 32'd1);
        check("en0_tog",  32'(TOG16), 32'd0);
        check("en0_qn",   32'(QN4),   32'hF);

        repeat (3) stepv(4'h0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
